// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

  // Serializer frame phases.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int StopBitsMax = 2;
  localparam int StopCntW    = $clog2(StopBitsMax);

  // A programmed bit period of zero behaves as one clock per bit.
  function automatic logic [15:0] bit_period(input logic [15:0] cpb);
    return (cpb == 16'd0) ? 16'd1 : cpb;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous byte FIFO: registered write, combinational head read, no fall-through.
module uart_tx_fifo_mem #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [Width-1:0]               wdata_i,
  output logic [Width-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     level_o
);

  localparam int AddrW = $clog2(Depth);
  localparam int PtrW  = AddrW + 1;
  localparam int LvlW  = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells a full buffer from an empty one.
  assign full_o  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);
  assign level_o = LvlW'(wr_ptr - rd_ptr);
  assign rdata_o = mem[rd_ptr[AddrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array write port.
  // NOTE: the data array has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AddrW-1:0]] <= wdata_i;
  end

  // Read and write pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: FIFO front end plus frame serializer.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int ParityEn  = 0,
  parameter int ParityOdd = 0,
  parameter int StopBits  = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               tx_en_i,
  input  logic [15:0]                        clks_per_bit_i,
  input  logic [7:0]                         wdata_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [$clog2(FifoDepth+1)-1:0]     level_o
);

  localparam int LvlW = $clog2(FifoDepth + 1);
  localparam logic [StopCntW-1:0] StopLast = StopCntW'(StopBits - 1);
  localparam logic ParityXor = (ParityOdd != 0);

  if (StopBits < 1 || StopBits > StopBitsMax) begin : g_bad_stop_bits
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of two >= 2");
  end

  tx_state_e           state;
  logic [15:0]         period;
  logic [15:0]         cnt;
  logic [2:0]          bit_idx;
  logic [StopCntW-1:0] stop_cnt;
  logic [7:0]          shift;
  logic                par_bit;

  logic                full;
  logic                empty;
  logic                pop;
  logic [7:0]          head;
  logic [LvlW-1:0]     level;
  logic                bit_end;
  logic                stop_final;
  logic                stop_entry_last;

  uart_tx_fifo_mem #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wvalid_i),
    .pop_i   (pop),
    .wdata_i (wdata_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign wready_o = !full;
  assign level_o  = level;
  assign busy_o   = (state != IDLE);

  assign bit_end    = (cnt == period - 16'd1);
  assign stop_final = (stop_cnt == StopLast);
  // With one stop bit of one clock, the first stop cycle is also the last.
  assign stop_entry_last = (StopBits == 1) && (period == 16'd1);

  // A frame starts from idle, or straight out of the final stop cycle for zero gap.
  assign pop = tx_en_i && !empty &&
               ((state == IDLE) || ((state == STOP) && bit_end && stop_final));

  // Frame sequencer with registered line and done outputs.
  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      period   <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_o     <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (pop) begin
        shift    <= head;
        period   <= bit_period(clks_per_bit_i);
        cnt      <= '0;
        bit_idx  <= '0;
        stop_cnt <= '0;
        par_bit  <= (^head) ^ ParityXor;
        tx_o     <= 1'b0;
        state    <= START;
      end else begin
        unique case (state)
          IDLE: begin
            tx_o <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              cnt   <= '0;
              tx_o  <= shift[0];
              state <= DATA;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= '0;
              if (bit_idx == 3'd7) begin
                bit_idx <= '0;
                if (ParityEn != 0) begin
                  tx_o  <= par_bit;
                  state <= PARITY;
                end else begin
                  tx_o   <= 1'b1;
                  state  <= STOP;
                  done_o <= stop_entry_last;
                end
              end else begin
                shift   <= shift >> 1;
                tx_o    <= shift[1];
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          PARITY: begin
            if (bit_end) begin
              cnt    <= '0;
              tx_o   <= 1'b1;
              state  <= STOP;
              done_o <= stop_entry_last;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              cnt <= '0;
              if (stop_final) begin
                stop_cnt <= '0;
                tx_o     <= 1'b1;
                state    <= IDLE;
              end else begin
                stop_cnt <= stop_cnt + StopCntW'(1);
                done_o   <= (period == 16'd1);
              end
            end else begin
              cnt    <= cnt + 16'd1;
              done_o <= stop_final && ((cnt + 16'd1) == (period - 16'd1));
            end
          end
          default: begin
            tx_o  <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: 8N1 instance plus an 8E2 instance.
module tb_uart_tx_fifo;

  localparam int LvlW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             tx_en_a, wvalid_a, wready_a, tx_a, busy_a, done_a;
  logic [15:0]      cpb_a;
  logic [7:0]       wdata_a;
  logic [LvlW-1:0]  level_a;
  logic             tx_en_b, wvalid_b, wready_b, tx_b, busy_b, done_b;
  logic [15:0]      cpb_b;
  logic [7:0]       wdata_b;
  logic [LvlW-1:0]  level_b;

  uart_tx_fifo #(.FifoDepth(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_en_i(tx_en_a), .clks_per_bit_i(cpb_a),
    .wdata_i(wdata_a), .wvalid_i(wvalid_a), .wready_o(wready_a), .tx_o(tx_a),
    .busy_o(busy_a), .done_o(done_a), .level_o(level_a)
  );

  uart_tx_fifo #(.FifoDepth(4), .ParityEn(1), .ParityOdd(0), .StopBits(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_en_i(tx_en_b), .clks_per_bit_i(cpb_b),
    .wdata_i(wdata_b), .wvalid_i(wvalid_b), .wready_o(wready_b), .tx_o(tx_b),
    .busy_o(busy_b), .done_o(done_b), .level_o(level_b)
  );

  // One single-frame vector: which instance, byte, programmed period,
  // effective period, frame length and expected bit-slot pattern (slot 0 = start).
  typedef struct {
    bit          sel;
    logic [7:0]  data;
    logic [15:0] cpb;
    int          p;
    int          len;
    logic [11:0] pat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tx_s(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction
  function automatic logic busy_s(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic done_s(input bit sel);
    return sel ? done_b : done_a;
  endfunction
  function automatic logic [LvlW-1:0] level_s(input bit sel);
    return sel ? level_b : level_a;
  endfunction

  // Behavioural 8N1 receiver on dut_a's line: samples each bit mid-period.
  logic        rx_on = 1'b0;
  int          rx_p  = 1;
  logic [7:0]  rx_q[$];

  initial begin : rx_model
    int   c;
    int   idx;
    bit   act;
    logic [7:0] sh;
    act = 1'b0;
    c   = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (!rx_on || rst_n !== 1'b1) begin
        act = 1'b0;
      end else begin
        if (!act) begin
          if (tx_a === 1'b0) begin
            act = 1'b1;
            c   = 0;
            sh  = '0;
          end
        end else begin
          c++;
        end
        if (act) begin
          if (c % rx_p == rx_p / 2) begin
            idx = c / rx_p;
            if (idx >= 1 && idx <= 8) sh[3'(idx - 1)] = tx_a;
            else if (idx == 9) check("rx_stop_bit", 32'(tx_a), 32'd1);
          end
          if (c == 10 * rx_p - 1) begin
            rx_q.push_back(sh);
            act = 1'b0;
          end
        end
      end
    end
  end

  // Push one byte into an idle instance and compare the whole frame.
  task automatic run_frame(input vec_t v);
    logic [11:0] pat;
    int          busy_n, done_n, done_at;
    bit          glitch;
    logic        t;
    @(negedge clk);
    if (v.sel) begin cpb_b = v.cpb; wdata_b = v.data; wvalid_b = 1'b1; end
    else       begin cpb_a = v.cpb; wdata_a = v.data; wvalid_a = 1'b1; end
    @(negedge clk);
    wvalid_a = 1'b0;
    wvalid_b = 1'b0;
    check("lat_tx_high", 32'(tx_s(v.sel)), 32'd1);
    check("lat_level",   32'(level_s(v.sel)), 32'd1);
    @(negedge clk);
    pat = '0; busy_n = 0; done_n = 0; done_at = -1; glitch = 1'b0;
    for (int c = 0; c < v.len; c++) begin
      if (c > 0) @(negedge clk);
      t = tx_s(v.sel);
      if (c % v.p == 0) pat[4'(c / v.p)] = t;
      else if (t !== pat[4'(c / v.p)]) glitch = 1'b1;
      if (busy_s(v.sel) === 1'b1) busy_n++;
      if (done_s(v.sel) === 1'b1) begin done_n++; done_at = c; end
    end
    check("frame_bits",   32'(pat), 32'(v.pat));
    check("bit_stable",   32'(glitch), 32'd0);
    check("busy_cycles",  32'(busy_n), 32'(v.len));
    check("done_count",   32'(done_n), 32'd1);
    check("done_cycle",   32'(done_at), 32'(v.len - 1));
    @(negedge clk);
    check("after_tx",     32'(tx_s(v.sel)), 32'd1);
    check("after_busy",   32'(busy_s(v.sel)), 32'd0);
    check("after_done",   32'(done_s(v.sel)), 32'd0);
  endtask

  // Stream bytes into dut_a with random valid gaps; compare the decoded line.
  task automatic stream(input int p, input logic [7:0] bytes[$]);
    int i;
    int guard;
    rx_q.delete();
    rx_p    = p;
    cpb_a   = 16'(p);
    tx_en_a = 1'b1;
    rx_on   = 1'b1;
    i = 0;
    guard = 0;
    while (i < bytes.size() && guard < 40000) begin
      @(negedge clk);
      guard++;
      wvalid_a = 1'b0;
      if (wready_a && $urandom_range(0, 3) != 0) begin
        wvalid_a = 1'b1;
        wdata_a  = bytes[i];
        i++;
      end
    end
    @(negedge clk);
    wvalid_a = 1'b0;
    while ((rx_q.size() < bytes.size() || busy_a) && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check("stream_count", 32'(rx_q.size()), 32'(bytes.size()));
    for (int k = 0; k < bytes.size() && k < rx_q.size(); k++)
      check("stream_byte", 32'(rx_q[k]), 32'(bytes[k]));
    rx_on = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    vec_t       vecs[8];
    logic [7:0] rnd[$];
    int         n, nd, d0, d1;
    logic       t29, t30, t33;

    vecs[0] = '{1'b0, 8'hA5, 16'd4, 4, 40, 12'h34A};
    vecs[1] = '{1'b0, 8'h00, 16'd3, 3, 30, 12'h200};
    vecs[2] = '{1'b0, 8'hFF, 16'd1, 1, 10, 12'h3FE};
    vecs[3] = '{1'b0, 8'h3C, 16'd0, 1, 10, 12'h278};
    vecs[4] = '{1'b0, 8'h81, 16'd2, 2, 20, 12'h302};
    vecs[5] = '{1'b1, 8'h07, 16'd2, 2, 24, 12'hE0E};
    vecs[6] = '{1'b1, 8'h03, 16'd3, 3, 36, 12'hC06};
    vecs[7] = '{1'b1, 8'hFF, 16'd1, 1, 12, 12'hDFE};

    rst_n = 1'b0;
    tx_en_a = 1'b0; tx_en_b = 1'b0;
    cpb_a = 16'd1;  cpb_b = 16'd1;
    wdata_a = '0;   wdata_b = '0;
    wvalid_a = 1'b0; wvalid_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_a",     32'(tx_a), 32'd1);
    check("rst_wready_a", 32'(wready_a), 32'd1);
    check("rst_busy_a",   32'(busy_a), 32'd0);
    check("rst_done_a",   32'(done_a), 32'd0);
    check("rst_level_a",  32'(level_a), 32'd0);
    check("rst_tx_b",     32'(tx_b), 32'd1);
    rst_n = 1'b1;
    tx_en_a = 1'b1;
    tx_en_b = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Hold transmission, overfill the FIFO, then release it.
    tx_en_a = 1'b0;
    cpb_a   = 16'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fill_wready", 32'(wready_a), (i < 4) ? 32'd1 : 32'd0);
      wvalid_a = 1'b1;
      wdata_a  = 8'(17 * (i + 1));
    end
    @(negedge clk);
    wvalid_a = 1'b0;
    check("full_level",  32'(level_a), 32'd4);
    check("full_wready", 32'(wready_a), 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) n++;
    end
    check("held_idle", 32'(n), 32'd0);
    rx_q.delete();
    rx_p  = 2;
    rx_on = 1'b1;
    tx_en_a = 1'b1;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) n++;
      if (rx_q.size() == 4 && busy_a === 1'b0) break;
    end
    repeat (10) begin
      @(negedge clk);
      if (busy_a !== 1'b0) n += 100;
    end
    check("drain_done",  32'(n), 32'd4);
    check("drain_count", 32'(rx_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx_q.size(); k++)
      check("drain_byte", 32'(rx_q[k]), 32'(8'(17 * (k + 1))));
    check("drain_level", 32'(level_a), 32'd0);
    rx_on = 1'b0;

    // Two frames back to back with no idle cycle between them.
    cpb_a = 16'd3;
    @(negedge clk); wvalid_a = 1'b1; wdata_a = 8'h00;
    @(negedge clk); wdata_a = 8'hFF;
    @(negedge clk); wvalid_a = 1'b0;
    check("b2b_level", 32'(level_a), 32'd1);
    check("b2b_start", 32'(tx_a), 32'd0);
    n = 0; nd = 0; d0 = -1; d1 = -1; t29 = 1'bx; t30 = 1'bx; t33 = 1'bx;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (busy_a !== 1'b1) break;
      n++;
      if (done_a === 1'b1) begin
        if (nd == 0) d0 = c; else d1 = c;
        nd++;
      end
      if (c == 29) t29 = tx_a;
      if (c == 30) t30 = tx_a;
      if (c == 33) t33 = tx_a;
    end
    check("b2b_active", 32'(n), 32'd60);
    check("b2b_stop1",  32'(t29), 32'd1);
    check("b2b_start2", 32'(t30), 32'd0);
    check("b2b_bit0",   32'(t33), 32'd1);
    check("b2b_ndone",  32'(nd), 32'd2);
    check("b2b_done0",  32'(d0), 32'd29);
    check("b2b_done1",  32'(d1), 32'd59);
    check("b2b_idle",   32'(tx_a), 32'd1);

    // Loopback byte sequence at a slow bit period, then random streams.
    rnd = {8'h00, 8'h55, 8'hAA, 8'hFF, 8'h3C};
    stream(87, rnd);
    for (int b = 0; b < 3; b++) begin
      rnd.delete();
      for (int k = 0; k < 12; k++) rnd.push_back(8'($urandom));
      stream(int'($urandom_range(1, 5)), rnd);
    end

    // Asynchronous reset in the middle of a data bit.
    cpb_a = 16'd4;
    tx_en_a = 1'b1;
    @(negedge clk); wvalid_a = 1'b1; wdata_a = 8'h3C;
    @(negedge clk); wdata_a = 8'h5A;
    @(negedge clk); wvalid_a = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_tx",    32'(tx_a), 32'd0);
    check("pre_rst_level", 32'(level_a), 32'd1);
    check("pre_rst_busy",  32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx",     32'(tx_a), 32'd1);
    check("arst_level",  32'(level_a), 32'd0);
    check("arst_busy",   32'(busy_a), 32'd0);
    check("arst_wready", 32'(wready_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || level_a !== '0) n++;
    end
    check("post_rst_quiet", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
